// File: rtl/mem_align_seq.sv
// Byte-lane aligner between the MEM stage and a word-wide data memory.
// Accesses that straddle a word boundary take two cycles with one stall.
module mem_align_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        access_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]  state;
  logic [31:0] low_word;
  logic [31:0] r_wdata;
  logic [29:0] r_base;
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic [2:0]  r_ltype;
  logic        r_read;
  logic        r_write;

  logic       err;
  logic       go_rd;
  logic       go_wr;
  logic       split;
  logic [2:0] ld_n;
  logic [2:0] st_n;
  logic [2:0] n;
  logic [3:0] lo_lanes;
  logic [3:0] hi_lanes;
  logic [31:0] joined;

  // Lane mask of an n-byte access at offset o; hi selects the next word.
  function automatic logic [3:0] lanes(
    input logic [2:0] sz,
    input logic [1:0] o,
    input logic       hi
  );
    logic [7:0] m;
    m = 8'h00;
    case (sz)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      3'd4:    m = 8'h0F;
      default: m = 8'h00;
    endcase
    m = m << o;
    return hi ? m[7:4] : m[3:0];
  endfunction

  function automatic logic [31:0] ext(
    input logic [31:0] raw,
    input logic [2:0]  lt
  );
    logic [31:0] v;
    v = '0;
    case (lt)
      3'b000:  v = {{24{raw[7]}}, raw[7:0]};
      3'b001:  v = {{16{raw[15]}}, raw[15:0]};
      3'b010:  v = raw;
      3'b011:  v = {24'd0, raw[7:0]};
      3'b100:  v = {16'd0, raw[15:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    ld_n = 3'd0;
    unique case (1'b1)
      (load_type == 3'b000),
      (load_type == 3'b011): ld_n = 3'd1;
      (load_type == 3'b001),
      (load_type == 3'b100): ld_n = 3'd2;
      (load_type == 3'b010): ld_n = 3'd4;
      default:               ld_n = 3'd0;
    endcase
  end

  always_comb begin
    st_n = 3'd0;
    unique case (1'b1)
      (store_type == 2'b00): st_n = 3'd1;
      (store_type == 2'b01): st_n = 3'd2;
      (store_type == 2'b10): st_n = 3'd4;
      default:               st_n = 3'd0;
    endcase
  end

  assign err   = req_valid & req_read & req_write;
  assign go_rd = req_valid & req_read & ~req_write & (ld_n != 3'd0);
  assign go_wr = req_valid & req_write & ~req_read & (st_n != 3'd0);
  assign n     = go_wr ? st_n : ld_n;
  assign split = (go_rd | go_wr) & (({1'b0, addr[1:0]} + n) > 3'd4);

  assign lo_lanes = lanes(n, addr[1:0], 1'b0);
  assign hi_lanes = lanes(r_size, r_off, 1'b1);
  assign joined   = 32'({mem_rdata, low_word} >> {r_off, 3'b000});

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = 4'b0000;
    load_data   = '0;
    stall       = 1'b0;
    done        = 1'b0;
    access_err  = 1'b0;
    if (!rst) begin
      mem_read = 1'b0;
    end else if (state == SECOND) begin
      mem_read    = r_read;
      mem_write   = r_write;
      mem_addr    = {r_base + 30'd1, 2'b00};
      mem_wdata   = r_wdata >> {3'd4 - {1'b0, r_off}, 3'b000};
      mem_byte_en = r_write ? hi_lanes : 4'b0000;
      load_data   = r_read ? ext(joined, r_ltype) : '0;
      done        = 1'b1;
    end else begin
      access_err  = err;
      mem_read    = go_rd;
      mem_write   = go_wr;
      mem_addr    = {addr[31:2], 2'b00};
      mem_wdata   = wdata << {addr[1:0], 3'b000};
      mem_byte_en = go_wr ? lo_lanes : 4'b0000;
      stall       = split;
      done        = req_valid & ~split;
      if (go_rd && !split)
        load_data = ext(mem_rdata >> {addr[1:0], 3'b000}, load_type);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      low_word <= '0;
      r_wdata  <= '0;
      r_base   <= '0;
      r_off    <= '0;
      r_size   <= '0;
      r_ltype  <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
    end else if (state == SECOND) begin
      state <= IDLE;
    end else if (split) begin
      state    <= SECOND;
      low_word <= mem_rdata;
      r_wdata  <= wdata;
      r_base   <= addr[31:2];
      r_off    <= addr[1:0];
      r_size   <= n;
      r_ltype  <= load_type;
      r_read   <= go_rd;
      r_write  <= go_wr;
    end
  end

endmodule

// File: tb/tb_mem_align_seq.sv
// Scoreboarded random bench for mem_align_seq with a byte-array
// reference memory and directed boundary cases.
module tb_mem_align_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        access_err;

  mem_align_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .load_type(load_type), .store_type(store_type),
    .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
    .load_data(load_data), .stall(stall), .done(done),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [11:0] ra;

  assign ra = mem_addr[11:0];
  assign mem_rdata = {mem[ra + 12'd3], mem[ra + 12'd2],
                      mem[ra + 12'd1], mem[ra]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i])
          mem[ra + 12'(i)] = mem_wdata[8*i +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-by-byte access into ref_mem, then extension.
  function automatic exp_t model(input logic rd, input logic wr,
                                 input logic [2:0] lt,
                                 input logic [1:0] st,
                                 input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t r;
    int n;
    logic sgn;
    logic [31:0] v;
    logic [11:0] k;
    r.ld = '0; r.err = 1'b0; r.lat = 1; r.cyc = cyc;
    n = 0; sgn = 1'b0; v = '0;
    if (rd && wr) begin
      r.err = 1'b1;
      return r;
    end
    if (rd) begin
      case (lt)
        3'd0: begin n = 1; sgn = 1'b1; end
        3'd1: begin n = 2; sgn = 1'b1; end
        3'd2: n = 4;
        3'd3: n = 1;
        3'd4: n = 2;
        default: n = 0;
      endcase
    end else if (wr) begin
      case (st)
        2'd0: n = 1;
        2'd1: n = 2;
        2'd2: n = 4;
        default: n = 0;
      endcase
    end
    if (n == 0) return r;
    if (int'(a % 4) + n > 4) r.lat = 2;
    for (int i = 0; i < n; i++) begin
      k = a[11:0] + 12'(i);
      if (wr) ref_mem[k] = wd[8*i +: 8];
      else v[8*i +: 8] = ref_mem[k];
    end
    if (rd) begin
      if (sgn && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      r.ld = v;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 expected none");
      end else begin
        e = q.pop_front();
        chk("sb_load", load_data, e.ld);
        chk("sb_err", 32'(access_err), 32'(e.err));
        chk("sb_latency", 32'(cyc - e.cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit push);
    exp_t e;
    if (push) begin
      e = model(rd, wr, lt, st, a, wd);
      q.push_back(e);
    end
    req_valid = 1'b1;
    req_read = rd;
    req_write = wr;
    load_type = lt;
    store_type = st;
    addr = a;
    wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] b);
    mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic op(input logic rd, input logic wr,
                    input logic [2:0] lt, input logic [1:0] st,
                    input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = 0;
    drive(rd, wr, lt, st, a, wd, 1'b1);
    @(negedge clk);
    while (done !== 1'b1 && k < 3) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got no done expected done at %h", a);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic rd, wr;
    logic [2:0] lt;
    logic [1:0] st;
    int r, bad;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    rst = 1'b0;
    wdata = 32'h0;
    drive(1'b1, 1'b0, 3'd2, 2'd0, 32'h102, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_byte_en", 32'(mem_byte_en), 32'h0);
    chk("rst_load", load_data, 32'h0);
    idle();
    tick();
    rst = 1'b1;
    tick();

    poke(12'h100, 8'hDD); poke(12'h101, 8'hCC);
    poke(12'h102, 8'hBB); poke(12'h103, 8'hAA);
    drive(1'b1, 1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 1'b1);
    @(negedge clk);
    chk("lw_stall", 32'(stall), 32'h0);
    chk("lw_done", 32'(done), 32'h1);
    chk("lw_load", load_data, 32'hAABBCCDD);
    tick();

    for (int i = 0; i < 8; i++) poke(12'h100 + 12'(i), 8'(i));
    drive(1'b1, 1'b0, 3'd2, 2'd0, 32'h102, 32'h0, 1'b1);
    @(negedge clk);
    chk("lws_stall1", 32'(stall), 32'h1);
    chk("lws_addr1", mem_addr, 32'h100);
    tick();
    @(negedge clk);
    chk("lws_addr2", mem_addr, 32'h104);
    chk("lws_done2", 32'(done), 32'h1);
    chk("lws_load", load_data, 32'h05040302);
    tick();

    drive(1'b0, 1'b1, 3'd0, 2'd1, 32'h203, 32'h1234, 1'b1);
    @(negedge clk);
    chk("sh_be1", 32'(mem_byte_en), 32'h8);
    chk("sh_addr1", mem_addr, 32'h200);
    tick();
    chk("sh_mem203", 32'(mem[12'h203]), 32'h34);
    @(negedge clk);
    chk("sh_addr2", mem_addr, 32'h204);
    chk("sh_be2", 32'(mem_byte_en), 32'h1);
    tick();
    chk("sh_mem204", 32'(mem[12'h204]), 32'h12);

    poke(12'h3FF, 8'h80); poke(12'h400, 8'hFF);
    drive(1'b1, 1'b0, 3'd1, 2'd0, 32'h3FF, 32'h0, 1'b1);
    @(negedge clk);
    chk("lh_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    chk("lh_load", load_data, 32'hFFFFFF80);
    tick();
    drive(1'b1, 1'b0, 3'd4, 2'd0, 32'h3FF, 32'h0, 1'b1);
    tick();
    @(negedge clk);
    chk("lhu_load", load_data, 32'h0000FF80);
    tick();

    drive(1'b0, 1'b1, 3'd0, 2'd2, 32'hFFFFFFFE, 32'hCAFEBABE, 1'b1);
    @(negedge clk);
    chk("sw_wrap_addr1", mem_addr, 32'hFFFFFFFC);
    chk("sw_wrap_be1", 32'(mem_byte_en), 32'hC);
    tick();
    @(negedge clk);
    chk("sw_wrap_addr2", mem_addr, 32'h0);
    chk("sw_wrap_be2", 32'(mem_byte_en), 32'h3);
    tick();

    drive(1'b0, 1'b1, 3'd0, 2'd2, 32'h501, 32'hA1B2C3D4, 1'b0);
    ref_mem[12'h501] = 8'hD4;
    ref_mem[12'h502] = 8'hC3;
    ref_mem[12'h503] = 8'hB2;
    @(negedge clk);
    chk("rsplit_stall", 32'(stall), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("rsplit_stall0", 32'(stall), 32'h0);
    chk("rsplit_done0", 32'(done), 32'h0);
    chk("rsplit_write0", 32'(mem_write), 32'h0);
    chk("rsplit_be0", 32'(mem_byte_en), 32'h0);
    chk("rsplit_load0", load_data, 32'h0);
    idle();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rsplit_idle", 32'(stall), 32'h0);
    chk("rsplit_mem504", 32'(mem[12'h504]), 32'(ref_mem[12'h504]));
    tick();

    drive(1'b1, 1'b1, 3'd2, 2'd2, 32'h40, 32'h55, 1'b1);
    @(negedge clk);
    chk("err_flag", 32'(access_err), 32'h1);
    chk("err_read", 32'(mem_read), 32'h0);
    chk("err_write", 32'(mem_write), 32'h0);
    chk("err_stall", 32'(stall), 32'h0);
    tick();

    drive(1'b1, 1'b0, 3'd5, 2'd0, 32'h80, 32'h0, 1'b1);
    @(negedge clk);
    chk("undef_ld_read", 32'(mem_read), 32'h0);
    chk("undef_ld_done", 32'(done), 32'h1);
    tick();
    drive(1'b0, 1'b1, 3'd0, 2'd3, 32'h80, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("undef_st_write", 32'(mem_write), 32'h0);
    chk("undef_st_be", 32'(mem_byte_en), 32'h0);
    tick();

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      if ($urandom_range(0, 9) == 0) lt = 3'($urandom_range(5, 7));
      else lt = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) st = 2'd3;
      else st = 2'($urandom_range(0, 2));
      op(rd, wr, lt, st, $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        idle();
        tick();
      end
    end

    idle();
    repeat (3) tick();
    chk("sb_drain", 32'(q.size()), 32'h0);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
